// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong game sequencer: still/run control, ball count, BCD score, pause timer
// Frozen except in PLAY; pauses count frame ticks after each miss and after game-over.
module pong_game_ctrl #(
  parameter int BALLS       = 3,
  parameter int WAIT_FRAMES = 120
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [1:0] btn,
  input  logic       hit,
  input  logic       miss,
  output logic       gra_still,
  output logic [1:0] state,
  output logic [1:0] balls_left,
  output logic [7:0] score,
  output logic [7:0] time_left
);

  typedef enum logic [1:0] {
    NEWGAME = 2'd0,
    PLAY    = 2'd1,
    NEWBALL = 2'd2,
    OVER    = 2'd3
  } state_t;

  localparam logic [1:0] BALLS_INIT = 2'(BALLS);
  localparam logic [7:0] WAIT_INIT  = 8'(WAIT_FRAMES);

  state_t st;
  logic   pressed;

  assign pressed = |btn;
  assign state   = st;

  // Two-digit BCD increment that sticks at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99)
      return v;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_ff @(posedge clock) begin
    if (!reset) begin
      st         <= NEWGAME;
      balls_left <= BALLS_INIT;
      score      <= 8'h00;
      time_left  <= 8'd0;
      gra_still  <= 1'b1;
    end else begin
      case (st)
        NEWGAME: begin
          if (pressed) begin
            st         <= PLAY;
            score      <= 8'h00;
            balls_left <= BALLS_INIT - 2'd1;
            gra_still  <= 1'b0;
          end
        end
        PLAY: begin
          if (hit)
            score <= bcd_inc(score);
          // Timer loads here; a coincident frame_tick is deliberately not counted.
          if (miss) begin
            time_left <= WAIT_INIT;
            gra_still <= 1'b1;
            if (balls_left == 2'd0) begin
              st <= OVER;
            end else begin
              balls_left <= balls_left - 2'd1;
              st         <= NEWBALL;
            end
          end
        end
        NEWBALL: begin
          if (time_left == 8'd0 && pressed) begin
            st        <= PLAY;
            gra_still <= 1'b0;
          end else if (frame_tick && time_left != 8'd0) begin
            time_left <= time_left - 8'd1;
          end
        end
        OVER: begin
          if (time_left == 8'd0) begin
            st         <= NEWGAME;
            balls_left <= BALLS_INIT;
          end else if (frame_tick) begin
            time_left <= time_left - 8'd1;
          end
        end
        default: begin
          st        <= NEWGAME;
          gra_still <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - scoreboard bench for pong_game_ctrl against a decimal-score game model
// Driver pushes predicted outputs per edge; monitor pops and compares after each edge.
module tb_pong_game_ctrl;

  localparam int BALLS = 3;
  localparam int WAITF = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic [1:0] btn = 2'b00;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic       gra_still;
  logic [1:0] state;
  logic [1:0] balls_left;
  logic [7:0] score;
  logic [7:0] time_left;

  pong_game_ctrl #(.BALLS(BALLS), .WAIT_FRAMES(WAITF)) dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick), .btn(btn),
    .hit(hit), .miss(miss), .gra_still(gra_still), .state(state),
    .balls_left(balls_left), .score(score), .time_left(time_left)
  );

  always #5 clock = ~clock;

  // Reference game: mode 0 idle, 1 playing, 2 between balls, 3 game over.
  int m_mode = 0, m_balls = BALLS, m_score = 0, m_time = 0;
  logic [20:0] exp_q[$];
  int n_checks = 0, n_fail = 0;

  function automatic logic [20:0] pack_exp();
    logic [7:0] s;
    s = {4'(m_score / 10), 4'(m_score % 10)};
    return {m_mode != 1, 2'(m_mode), 2'(m_balls), s, 8'(m_time)};
  endfunction

  task automatic model_step(input logic r, input logic [1:0] b, input logic h,
                            input logic m, input logic t);
    if (!r) begin
      m_mode = 0; m_balls = BALLS; m_score = 0; m_time = 0;
    end else begin
      case (m_mode)
        0: if (b != 0) begin m_mode = 1; m_score = 0; m_balls = BALLS - 1; end
        1: begin
          if (h && m_score < 99) m_score++;
          if (m) begin
            m_time = WAITF;
            if (m_balls == 0) m_mode = 3;
            else begin m_balls--; m_mode = 2; end
          end
        end
        2: begin
          if (m_time == 0 && b != 0) m_mode = 1;
          else if (t && m_time > 0) m_time--;
        end
        default: begin
          if (m_time == 0) begin m_mode = 0; m_balls = BALLS; end
          else if (t) m_time--;
        end
      endcase
    end
  endtask

  task automatic cycle(input logic r, input logic [1:0] b, input logic h,
                       input logic m, input logic t, input bit glitch = 1'b0);
    @(negedge clock);
    reset = r; btn = b; hit = h; miss = m; frame_tick = t;
    model_step(r, b, h, m, t);
    exp_q.push_back(pack_exp());
    // Reset pulse confined between edges must not be seen.
    if (glitch) begin
      #1 reset = 1'b0;
      #2 reset = 1'b1;
    end
  endtask

  always @(posedge clock) begin
    logic [20:0] e, a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {gra_still, state, balls_left, score, time_left};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs t=%0t still/state/balls/score/time got %0b/%0d/%0d/%h/%0d want %0b/%0d/%0d/%h/%0d",
                 $time, a[20], a[19:18], a[17:16], a[15:8], a[7:0],
                 e[20], e[19:18], e[17:16], e[15:8], e[7:0]);
      end
    end
  end

  initial begin
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 1, 1, 1);
    cycle(1, 2'b01, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      cycle(1, 0, 1, 0, 0);
      cycle(1, 2'b11, 0, 0, 0);
    end
    for (int i = 0; i < 90; i++) cycle(1, 0, 1, 0, 0);
    cycle(1, 0, 0, 1, 0);
    for (int i = 0; i < WAITF; i++) begin
      cycle(1, 2'b10, 1, 1, 1);
      cycle(1, 2'b10, 0, 0, 0);
    end
    cycle(1, 0, 0, 1, 1);
    for (int i = 0; i < WAITF; i++) cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
    cycle(1, 2'b01, 0, 0, 0);
    cycle(1, 0, 0, 1, 0);
    for (int i = 0; i < WAITF; i++) begin
      cycle(1, 2'b11, 1, 1, 1);
      cycle(1, 0, 0, 0, 0);
    end
    cycle(1, 0, 0, 0, 0);
    cycle(1, 2'b10, 0, 0, 0);
    for (int i = 0; i < 9; i++) cycle(1, 0, 1, 0, 0);
    cycle(1, 0, 1, 1, 1);
    cycle(1, 0, 0, 0, 1);
    cycle(0, 2'b01, 1, 1, 1);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 2'b01, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 1'b1);
    cycle(1, 0, 1, 0, 0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      logic       r, h, m, t;
      logic [1:0] b;
      r = ($urandom_range(199) != 0);
      b = ($urandom_range(3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      h = ($urandom_range(3) == 0);
      m = ($urandom_range(15) == 0);
      t = ($urandom_range(2) == 0);
      cycle(r, b, h, m, t);
    end
    repeat (3) @(posedge clock);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Top-level game sequencer for the pong VGA datapath. It decides when the graphics/animation block is frozen or running, counts remaining balls, and keeps a 2-digit BCD score. It also times the pauses between balls and after game-over using the per-frame refresh tick. It sits beside the animation block: it consumes that block's hit/miss pulses and drives its still/run control.

Parameters:
BALLS, 3, balls per game; legal range 1..3 (balls_left is 2 bits).
WAIT_FRAMES, 120, pause length in frames after a miss or game-over; legal range 1..255.

Ports:
clock  in  1  system clock; all logic on its rising edge.
reset  in  1  synchronous, active-low reset.
frame_tick  in  1  one-clock pulse per video frame, at most one per frame.
btn  in  2  player buttons; "pressed" means btn != 2'b00.
hit  in  1  one-clock pulse: ball struck paddle.
miss  in  1  one-clock pulse: ball passed paddle.
gra_still  out  1  1 = animation frozen, ball parked; 0 = animation runs.
state  out  2  game state: 0 NEWGAME, 1 PLAY, 2 NEWBALL, 3 OVER.
balls_left  out  2  balls remaining after the one in play.
score  out  8  BCD; [7:4] = tens, [3:0] = units.
time_left  out  8  pause timer value.

Behaviour:
- Interface: one clock, `clock`. Reset is synchronous and active-low on `reset`; it is sampled only at the clock edge.
- All outputs are registered. gra_still is decoded registered: it is 0 only in PLAY.
- Reset (reset=0 at an edge) sets:
  - state=NEWGAME, balls_left=BALLS, score=8'h00, time_left=0, gra_still=1.
  - Reset overrides every other input in the same cycle.
  - Reset mid-pause or mid-play aborts immediately; no residual timer.
- NEWGAME (0):
  - Waits for a button press.
  - btn != 0 → next state PLAY; score cleared to 8'h00; balls_left=BALLS-1.
  - hit, miss and frame_tick are ignored.
  - The score from the previous game stays visible in this state.
- PLAY (1):
  - hit → score increments in BCD: units 9 wraps to 0 with a carry into tens; saturates at 8'h99.
  - miss with balls_left=0 → next state OVER, time_left=WAIT_FRAMES.
  - miss with balls_left>0 → balls_left−1, next state NEWBALL, time_left=WAIT_FRAMES.
  - hit and miss in the same cycle: both take effect (score increments and the miss transition happens).
  - btn is ignored.
- NEWBALL (2):
  - On frame_tick with time_left != 0, time_left decrements by 1.
  - Transition to PLAY only when time_left==0 and btn != 0, evaluated in the same cycle. A button held through the pause therefore launches on the first cycle after the timer reaches 0.
  - hit and miss are ignored.
- OVER (3):
  - Timer decrements as in NEWBALL.
  - When time_left==0 → NEWGAME and balls_left reloads to BALLS.
  - btn, hit and miss are ignored.
  - The score is held.
- Timer rules:
  - 8-bit, never wraps below 0.
  - It is loaded only on the miss transition.
  - A frame_tick in the load cycle is ignored, so the pause lasts exactly WAIT_FRAMES frame_ticks.
- Latency: every input affects the outputs at the next rising edge (1 cycle).
- An implementation is roughly 150 lines of RTL: FSM, BCD counter, timer, ball counter.

Test Plan:
- Reset and start: hold reset=0 for 2 clocks, release with btn=0 → state=0, gra_still=1, balls_left=3, score=00. Pulse btn=2'b01 → next cycle state=1, gra_still=0, balls_left=2.
- BCD score: in PLAY send 12 hit pulses → score=8'h12. Preload to 98, send 3 hits → 8'h99 (saturates).
- Miss and pause (WAIT_FRAMES=4): miss in PLAY → state=2, time_left=4, balls_left=1. Hold btn=2'b10 throughout and give 3 frame_ticks → still state 2, time_left=1. 4th tick → time_left=0; next cycle state=1.
- Game over: BALLS=3, deliver 3 misses with pauses between them → after the 3rd miss state=3, balls_left=0. After 4 frame_ticks state=0, balls_left=3, score retained. Next btn press clears score to 00.
- Simultaneous hit and miss in PLAY with score=8'h09 → score=8'h10 and state=2 in the same next cycle. A frame_tick coincident with the miss leaves time_left=4.
- Reset mid-pause: in NEWBALL with time_left=3, assert reset=0 → next edge state=0, time_left=0, score=00, balls_left=3. A reset pulse between clock edges that misses every edge has no effect.
